// File: rtl/ddr_local_port_arbiter.sv
// Two-port round-robin arbiter in front of the DDR controller local interface.
// Write bursts are kept atomic; a tag FIFO steers returning read beats back to the issuing port.
module ddr_local_port_arbiter #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 23,
    parameter int SIZE_BITS = 2,
    parameter int TAG_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   p0_read_req,
    input  logic                   p0_write_req,
    input  logic [SIZE_BITS-1:0]   p0_size,
    input  logic [ADDR_BITS-1:0]   p0_addr,
    input  logic [DATA_BITS-1:0]   p0_wdata,
    input  logic [DATA_BITS/8-1:0] p0_be,
    output logic                   p0_ready,
    output logic [DATA_BITS-1:0]   p0_rdata,
    output logic                   p0_rdata_valid,
    input  logic                   p1_read_req,
    input  logic                   p1_write_req,
    input  logic [SIZE_BITS-1:0]   p1_size,
    input  logic [ADDR_BITS-1:0]   p1_addr,
    input  logic [DATA_BITS-1:0]   p1_wdata,
    input  logic [DATA_BITS/8-1:0] p1_be,
    output logic                   p1_ready,
    output logic [DATA_BITS-1:0]   p1_rdata,
    output logic                   p1_rdata_valid,
    input  logic                   ctl_init_done,
    input  logic                   ctl_ready,
    output logic                   ctl_read_req,
    output logic                   ctl_write_req,
    output logic                   ctl_burstbegin,
    output logic [SIZE_BITS-1:0]   ctl_size,
    output logic [ADDR_BITS-1:0]   ctl_addr,
    output logic [DATA_BITS-1:0]   ctl_wdata,
    output logic [DATA_BITS/8-1:0] ctl_be,
    input  logic [DATA_BITS-1:0]   ctl_rdata,
    input  logic                   ctl_rdata_valid,
    output logic                   rd_underflow
);
    localparam int BE_BITS  = DATA_BITS / 8;
    localparam int PTR_BITS = $clog2(TAG_DEPTH);

    typedef enum logic {IDLE, WBURST} state_e;

    typedef struct packed {
        logic                 port;
        logic [SIZE_BITS-1:0] size;
    } tag_t;

    function automatic logic [SIZE_BITS-1:0] norm_size(input logic [SIZE_BITS-1:0] s);
        return (s == '0) ? SIZE_BITS'(1) : s;
    endfunction

    // Per-port views so the winner can be selected by index
    logic [1:0]           rd_req, wr_req;
    logic [SIZE_BITS-1:0] req_size  [2];
    logic [ADDR_BITS-1:0] req_addr  [2];
    logic [DATA_BITS-1:0] req_wdata [2];
    logic [BE_BITS-1:0]   req_be    [2];

    assign rd_req       = {p1_read_req, p0_read_req};
    assign wr_req       = {p1_write_req, p0_write_req};
    assign req_size[0]  = p0_size;
    assign req_size[1]  = p1_size;
    assign req_addr[0]  = p0_addr;
    assign req_addr[1]  = p1_addr;
    assign req_wdata[0] = p0_wdata;
    assign req_wdata[1] = p1_wdata;
    assign req_be[0]    = p0_be;
    assign req_be[1]    = p1_be;

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 owner_q, owner_d;
    logic [SIZE_BITS-1:0] beats_left_q, beats_left_d;
    logic [SIZE_BITS-1:0] burst_size_q, burst_size_d;

    tag_t                 tag_mem [TAG_DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_BITS:0]    count_q;
    logic [SIZE_BITS-1:0] beat_cnt_q;
    logic [DATA_BITS-1:0] rdata_q;
    logic [1:0]           rvalid_q;
    logic                 underflow_q;

    logic                 fifo_full, fifo_empty;
    logic [1:0]           elig;
    logic                 winner, fwd_rd, fwd_wr, fwd_fields, accepted;
    logic                 push, pop, ret;
    tag_t                 push_tag, head_tag;

    assign fifo_full  = (count_q == (PTR_BITS+1)'(TAG_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head_tag   = tag_mem[rd_ptr_q];

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        beats_left_d   = beats_left_q;
        burst_size_d   = burst_size_q;
        winner         = 1'b0;
        fwd_rd         = 1'b0;
        fwd_wr         = 1'b0;
        fwd_fields     = 1'b0;
        push           = 1'b0;
        push_tag       = '0;
        ctl_read_req   = 1'b0;
        ctl_write_req  = 1'b0;
        ctl_burstbegin = 1'b0;
        ctl_size       = '0;
        ctl_addr       = '0;
        ctl_wdata      = '0;
        ctl_be         = '0;

        // A port asserting both requests is arbitrated as a writer
        elig[0] = wr_req[0] | (rd_req[0] & ~fifo_full);
        elig[1] = wr_req[1] | (rd_req[1] & ~fifo_full);

        if (state_q == IDLE) begin
            winner     = (&elig) ? ~last_grant_q : elig[1];
            fwd_fields = (|elig) & ctl_init_done & ~reset;
            fwd_wr     = fwd_fields & wr_req[winner];
            fwd_rd     = fwd_fields & ~wr_req[winner];
        end else begin
            winner     = owner_q;
            fwd_fields = ctl_init_done & ~reset;
            fwd_wr     = fwd_fields & wr_req[owner_q];
        end

        if (fwd_fields) begin
            ctl_read_req   = fwd_rd;
            ctl_write_req  = fwd_wr;
            ctl_burstbegin = (state_q == IDLE) & (fwd_rd | fwd_wr);
            ctl_size       = (state_q == IDLE) ? req_size[winner] : burst_size_q;
            ctl_addr       = req_addr[winner];
            ctl_wdata      = req_wdata[winner];
            ctl_be         = req_be[winner];
        end

        accepted = (fwd_rd | fwd_wr) & ctl_ready;
        push_tag = '{port: winner, size: norm_size(req_size[winner])};

        if (accepted) begin
            if (state_q == IDLE) begin
                if (fwd_rd) begin
                    push         = 1'b1;
                    last_grant_d = winner;
                end else if (norm_size(req_size[winner]) == SIZE_BITS'(1)) begin
                    last_grant_d = winner;
                end else begin
                    owner_d      = winner;
                    beats_left_d = norm_size(req_size[winner]) - SIZE_BITS'(1);
                    burst_size_d = norm_size(req_size[winner]);
                    state_d      = WBURST;
                end
            end else begin
                beats_left_d = beats_left_q - SIZE_BITS'(1);
                if (beats_left_q == SIZE_BITS'(1)) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
        end

        ret = ctl_rdata_valid & ~fifo_empty;
        pop = ret & ((beat_cnt_q + SIZE_BITS'(1)) == head_tag.size);
    end

    assign p0_ready       = accepted & ~winner;
    assign p1_ready       = accepted & winner;
    assign p0_rdata       = rdata_q;
    assign p1_rdata       = rdata_q;
    assign p0_rdata_valid = rvalid_q[0];
    assign p1_rdata_valid = rvalid_q[1];
    assign rd_underflow   = underflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            beats_left_q <= '0;
            burst_size_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            beats_left_q <= beats_left_d;
            burst_size_q <= burst_size_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= push_tag;
        end
    end

    // Occupancy is registered, so a same-cycle pop cannot make room for a push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            beat_cnt_q  <= '0;
            rdata_q     <= '0;
            rvalid_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_BITS+1)'(1);
                2'b01:   count_q <= count_q - (PTR_BITS+1)'(1);
                default: count_q <= count_q;
            endcase
            rvalid_q <= ret ? (head_tag.port ? 2'b10 : 2'b01) : 2'b00;
            if (ret) begin
                rdata_q    <= ctl_rdata;
                beat_cnt_q <= pop ? '0 : beat_cnt_q + SIZE_BITS'(1);
            end
            if (ctl_rdata_valid & fifo_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end
endmodule

// File: doc/ddr_local_port_arbiter.md
# ddr_local_port_arbiter

Two-port round-robin arbiter that shares the single local (Avalon-style) request interface of the DDR SDRAM controller between two masters. It sits between the bus-side ports and the controller's local interface. It sequences multi-beat write bursts atomically and tracks outstanding reads in a tag FIFO so that returning read data is steered back to the port that issued the read. The controller runs with wdata presented alongside write_req (Avalon mode), local burst length up to 2, and a 23-bit flattened local address (cs+row+bank+col).

## Interface
- DATA_BITS, 32, local data width
- ADDR_BITS, 23, flattened local address width
- SIZE_BITS, 2, burst size field width
- TAG_DEPTH, 8, outstanding-read tag FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  controller clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-high
- pN_read_req, pN_write_req  in  1  per-port requests (N = 0, 1)
- pN_size  in  SIZE_BITS  burst beats; 0 is treated as 1
- pN_addr  in  ADDR_BITS  request address
- pN_wdata  in  DATA_BITS  write data
- pN_be  in  DATA_BITS/8  byte enables
- pN_ready  out  1  request or beat accepted this cycle
- pN_rdata  out  DATA_BITS  read data, registered, common to both ports
- pN_rdata_valid  out  1  read beat for port N
- ctl_init_done  in  1  controller calibrated/initialised
- ctl_ready  in  1  controller local_ready
- ctl_read_req, ctl_write_req, ctl_burstbegin  out  1  to controller
- ctl_size  out  SIZE_BITS; ctl_addr  out  ADDR_BITS; ctl_wdata  out  DATA_BITS; ctl_be  out  DATA_BITS/8
- ctl_rdata  in  DATA_BITS; ctl_rdata_valid  in  1  from controller
- rd_underflow  out  1  sticky error: rdata_valid arrived with no tag outstanding

## Operation
- FSM states: IDLE, WBURST.
- IDLE:
  - Port eligibility: a port is eligible if it asserts write_req, or asserts read_req while the tag FIFO is not full. A port asserting both is treated as a write.
  - Winner: the eligible port; if both are eligible, the port not equal to last_grant wins.
  - The winner's request fields are muxed combinationally onto ctl_*. ctl_burstbegin = ctl_read_req | ctl_write_req. The loser's ctl_* contribution is zero.
  - Nothing is forwarded while ctl_init_done = 0.
- Acceptance: accepted = winner request & ctl_ready & ctl_init_done. pN_ready = accepted & (winner == N).
- Accepted read:
  - Push tag {port, size'} into the FIFO, where size' = max(size, 1).
  - last_grant ← port.
  - Remain in IDLE.
- Accepted write:
  - If size' = 1: last_grant ← port and remain in IDLE.
  - Otherwise: owner ← port, beats_left ← size' − 1, go to WBURST.
- WBURST:
  - Only the owner is muxed; ctl_write_req = owner write_req; ctl_burstbegin = 0; ctl_size holds the burst's size.
  - The other port and the owner's read_req see ready = 0.
  - Each accepted beat decrements beats_left. On the final beat: last_grant ← owner, go to IDLE.
- Read return:
  - When ctl_rdata_valid = 1 and the FIFO is not empty: register ctl_rdata onto both pN_rdata, and pulse pN_rdata_valid for the port at the FIFO head.
  - Beat counter increments per beat; when it equals the head size, pop the FIFO and clear the counter.
  - ctl_rdata_valid with the FIFO empty: drop the data and set rd_underflow (cleared only by reset).
- FIFO full test uses the registered count, so a simultaneous pop does not free a slot in the same cycle.
- Push and pop in the same cycle are legal; the count is unchanged.

## Timing
- Request path is combinational: pN_* → ctl_* and ctl_ready → pN_ready, with zero cycles of latency.
- Read data latency is exactly 1 cycle from ctl_rdata_valid to pN_rdata_valid.
- Reset values:
  - All registered outputs are 0, including pN_rdata, pN_rdata_valid and rd_underflow.
  - FSM = IDLE, last_grant = 1 (so port 0 wins the first tie), FIFO empty, counters 0.
- Combinational outputs are 0 while reset is asserted.
- Reset mid-burst or with reads outstanding abandons all state; no valid pulses are generated after reset deasserts.
- Masters must hold their request stable until pN_ready is seen. The arbiter may switch the winner only in IDLE, and only after an acceptance.

## Test plan
- Both ports read simultaneously and repeatedly, ctl_ready = 1 → grants alternate 0,1,0,1. Tags are returned in order, and each rdata_valid goes to the correct port one cycle after ctl_rdata_valid.
- Port 0 writes size 2 while port 1 requests a read in the first cycle, with ctl_ready low in the second cycle → port 1 is held off for the whole burst. Beat 2 carries burstbegin = 0 and waits for ctl_ready. Port 1 is granted in the cycle after the final beat.
- Port 1 issues 8 single-beat reads with no return (TAG_DEPTH = 8) → the 9th read is stalled (p1_ready = 0) while port 0 writes still proceed. One return pops a tag, and the read is accepted the following cycle.
- A size-2 read on port 0 followed by a size-1 read on port 1, with 3 back-to-back ctl_rdata_valid beats → p0_rdata_valid on beats 1–2, p1_rdata_valid on beat 3, and the FIFO ends empty.
- ctl_rdata_valid with no outstanding read → no pN_rdata_valid, and rd_underflow = 1 until reset.
- Assert reset mid write burst with 2 reads outstanding → all outputs are 0, and subsequent returns set rd_underflow rather than producing valid pulses; after reset, with both ports requesting, port 0 wins first arbitration.
